// File: rtl/adc_fill_pkg.sv
// adc_fill_pkg: shared fill-type encodings, FSM state enum and count width default
package adc_fill_pkg;
  localparam int CNT_W_DEF = 23;
  localparam logic [1:0] FILL_NONE  = 2'b00;
  localparam logic [1:0] FILL_MUON  = 2'b01;
  localparam logic [1:0] FILL_LASER = 2'b10;
  localparam logic [1:0] FILL_PED   = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACQUIRE, ST_DONE} state_e;
endpackage

// File: rtl/adc_fill_sequencer_if.sv
// adc_fill_sequencer_if: trigger, sizing, burst stream and completion signals of one fill sequencer
interface adc_fill_sequencer_if
  import adc_fill_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FILLNUM_W = 24
);
  logic                 trigger;
  logic [1:0]           trigger_type;
  logic [CNT_W-1:0]     num_muon_bursts;
  logic [CNT_W-1:0]     num_laser_bursts;
  logic [CNT_W-1:0]     num_ped_bursts;
  logic                 burst_valid;
  logic                 burst_ready;
  logic                 acq_enable;
  logic                 busy;
  logic [1:0]           fill_type;
  logic [CNT_W-1:0]     fill_bursts;
  logic [CNT_W-1:0]     bursts_done;
  logic [FILLNUM_W-1:0] fill_number;
  logic                 fill_done;
  logic                 done_ack;
  logic [7:0]           missed_triggers;
  logic                 timeout_flag;
  modport master (
    output trigger, trigger_type, num_muon_bursts, num_laser_bursts, num_ped_bursts,
    output burst_valid, done_ack,
    input  burst_ready, acq_enable, busy, fill_type, fill_bursts, bursts_done,
    input  fill_number, fill_done, missed_triggers, timeout_flag
  );
  modport slave (
    input  trigger, trigger_type, num_muon_bursts, num_laser_bursts, num_ped_bursts,
    input  burst_valid, done_ack,
    output burst_ready, acq_enable, busy, fill_type, fill_bursts, bursts_done,
    output fill_number, fill_done, missed_triggers, timeout_flag
  );
endinterface

// File: rtl/adc_fill_size_sel.sv
// adc_fill_size_sel: resolves fill type to burst count, registered when enabled (LOAD)
module adc_fill_size_sel
  import adc_fill_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [1:0]       type_i,
  input  logic [CNT_W-1:0] muon_i,
  input  logic [CNT_W-1:0] laser_i,
  input  logic [CNT_W-1:0] ped_i,
  output logic [CNT_W-1:0] sel_o,
  output logic [CNT_W-1:0] size_o
);
  logic [CNT_W-1:0] size_d, size_q;
  // type-to-size mux; FILL_NONE resolves to an empty fill
  always_comb
    size_d = type_i == FILL_MUON  ? muon_i  :
             type_i == FILL_LASER ? laser_i :
             type_i == FILL_PED   ? ped_i   : '0;
  // size is captured once per fill so later register writes do not disturb it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) size_q <= '0;
    else if (en_i) size_q <= size_d;
  assign sel_o  = size_d;
  assign size_o = size_q;
endmodule

// File: rtl/adc_fill_sequencer.sv
// adc_fill_sequencer: trigger-to-completion fill FSM; optional watchdog via ADC_FILL_SEQ_TIMEOUT_EN
module adc_fill_sequencer
  import adc_fill_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int FILLNUM_W      = 24,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                clk,
  input logic                rst_n,
  adc_fill_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_LOAD = ST_LOAD;
  localparam logic [1:0] S_ACQ  = ST_ACQUIRE;
  localparam logic [1:0] S_DONE = ST_DONE;
  logic [1:0]           state_q, state_d, type_q, type_d;
  logic [CNT_W-1:0]     done_q, done_d, size_sel, size_q;
  logic [FILLNUM_W-1:0] fnum_q, fnum_d;
  logic [7:0]           miss_q, miss_d;
  logic                 start, accept, wd_hit;
  assign start  = state_q == S_IDLE && bus.trigger;
  assign accept = bus.burst_valid && bus.burst_ready;
  adc_fill_size_sel #(.CNT_W(CNT_W)) u_size (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == S_LOAD),
    .type_i (type_q),
    .muon_i (bus.num_muon_bursts),
    .laser_i(bus.num_laser_bursts),
    .ped_i  (bus.num_ped_bursts),
    .sel_o  (size_sel),
    .size_o (size_q)
  );
`ifdef ADC_FILL_SEQ_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
  assign wd_hit = state_q == S_ACQ && !accept && wd_q == 16'(TIMEOUT_CYCLES - 1);
  // idle-burst watchdog, restarted by every accepted burst; flag cleared by the next trigger
  always_comb begin
    wd_d      = (state_q != S_ACQ || accept) ? '0 : wd_q + 16'd1;
    timeout_d = start ? 1'b0 : wd_hit ? 1'b1 : timeout_q;
  end
  // watchdog state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  assign bus.timeout_flag = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg       = ^TIMEOUT_CYCLES;
  assign wd_hit           = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif
  // next-state and per-fill bookkeeping
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    done_d  = done_q;
    fnum_d  = fnum_q;
    miss_d  = (bus.trigger && state_q != S_IDLE && miss_q != 8'hff) ? miss_q + 8'd1 : miss_q;
    case (state_q)
      S_IDLE:
        if (bus.trigger) begin
          type_d  = bus.trigger_type;
          fnum_d  = fnum_q + 1'b1;
          done_d  = '0;
          state_d = S_LOAD;
        end
      S_LOAD: state_d = size_sel == '0 ? S_DONE : S_ACQ;
      S_ACQ:
        if (accept) begin
          done_d  = done_q + 1'b1;
          state_d = done_d == size_q ? S_DONE : S_ACQ;
        end else if (wd_hit) begin
          state_d = S_DONE;
        end
      default: state_d = bus.done_ack ? S_IDLE : S_DONE;
    endcase
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      type_q  <= FILL_NONE;
      done_q  <= '0;
      fnum_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      done_q  <= done_d;
      fnum_q  <= fnum_d;
      miss_q  <= miss_d;
    end
  assign bus.acq_enable      = state_q == S_ACQ;
  assign bus.burst_ready     = state_q == S_ACQ && done_q != size_q;
  assign bus.busy            = state_q != S_IDLE;
  assign bus.fill_done       = state_q == S_DONE;
  assign bus.fill_type       = type_q;
  assign bus.fill_bursts     = size_q;
  assign bus.bursts_done     = done_q;
  assign bus.fill_number     = fnum_q;
  assign bus.missed_triggers = miss_q;
endmodule

// File: tb/tb_adc_fill_sequencer.sv
// tb_adc_fill_sequencer: directed scenario bench for adc_fill_sequencer
module tb_adc_fill_sequencer;
`ifdef ADC_FILL_SEQ_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  adc_fill_sequencer_if bus ();
  adc_fill_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ack();
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({bus.busy, bus.acq_enable, bus.burst_ready, bus.fill_done, bus.timeout_flag} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000",
               {bus.busy, bus.acq_enable, bus.burst_ready, bus.fill_done, bus.timeout_flag});
    else pass_cnt++;
    total_cnt++;
    if ({bus.fill_type, bus.fill_bursts, bus.bursts_done} !== '0)
      $display("FAIL reset_fill got type=%0d size=%0d done=%0d want 0", bus.fill_type, bus.fill_bursts, bus.bursts_done);
    else pass_cnt++;
    total_cnt++;
    if ({bus.fill_number, bus.missed_triggers} !== '0)
      $display("FAIL reset_counts got fnum=%0d miss=%0d want 0", bus.fill_number, bus.missed_triggers);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_muon();
    int acc = 0;
    bus.num_muon_bursts = 23'd5;
    bus.burst_valid = 1'b1;
    bus.trigger = 1'b1;
    bus.trigger_type = 2'b01;
    tick();
    bus.trigger = 1'b0;
    total_cnt++;
    if ({bus.busy, bus.acq_enable, bus.fill_type} !== 4'b1001 || bus.fill_number !== 24'd1)
      $display("FAIL muon_load got busy=%b acq=%b type=%0d fnum=%0d want 1 0 1 1",
               bus.busy, bus.acq_enable, bus.fill_type, bus.fill_number);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.acq_enable !== 1'b1 || bus.fill_bursts !== 23'd5 || bus.bursts_done !== 23'd0)
      $display("FAIL muon_acq_start got acq=%b size=%0d done=%0d want 1 5 0",
               bus.acq_enable, bus.fill_bursts, bus.bursts_done);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (bus.burst_ready) acc++;
      if (i == 4) begin
        total_cnt++;
        if (bus.fill_done !== 1'b0 || bus.bursts_done !== 23'd4)
          $display("FAIL muon_pre_last got done=%b cnt=%0d want 0 4", bus.fill_done, bus.bursts_done);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (acc != 5 || bus.fill_done !== 1'b1 || bus.bursts_done !== 23'd5 || bus.acq_enable !== 1'b0)
      $display("FAIL muon_done got acc=%0d done=%b cnt=%0d acq=%b want 5 1 5 0",
               acc, bus.fill_done, bus.bursts_done, bus.acq_enable);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.fill_done !== 1'b1 || bus.bursts_done !== 23'd5 || bus.burst_ready !== 1'b0 || bus.fill_number !== 24'd1)
      $display("FAIL muon_hold got done=%b cnt=%0d rdy=%b fnum=%0d want 1 5 0 1",
               bus.fill_done, bus.bursts_done, bus.burst_ready, bus.fill_number);
    else pass_cnt++;
    ack();
    total_cnt++;
    if (bus.fill_done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL muon_ack got done=%b busy=%b want 0 0", bus.fill_done, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_none();
    logic saw = 1'b0;
    bus.trigger = 1'b1;
    bus.trigger_type = 2'b00;
    tick();
    bus.trigger = 1'b0;
    saw |= bus.burst_ready;
    tick();
    saw |= bus.burst_ready;
    tick();
    saw |= bus.burst_ready;
    total_cnt++;
    if (bus.fill_done !== 1'b1 || bus.fill_bursts !== 23'd0 || saw !== 1'b0 || bus.fill_number !== 24'd2)
      $display("FAIL none_done got done=%b size=%0d saw_rdy=%b fnum=%0d want 1 0 0 2",
               bus.fill_done, bus.fill_bursts, saw, bus.fill_number);
    else pass_cnt++;
    ack();
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.fill_done !== 1'b0)
      $display("FAIL none_ack got busy=%b done=%b want 0 0", bus.busy, bus.fill_done);
    else pass_cnt++;
  endtask

  task automatic test_missed();
    bus.num_laser_bursts = 23'd1000;
    bus.burst_valid = 1'b0;
    bus.trigger_type = 2'b10;
    bus.trigger = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    total_cnt++;
    if (bus.missed_triggers !== 8'd10)
      $display("FAIL missed_count got %0d want 10", bus.missed_triggers);
    else pass_cnt++;
    for (int i = 0; i < 289; i++) tick();
    bus.trigger = 1'b0;
    total_cnt++;
    if (bus.missed_triggers !== 8'd255 || bus.bursts_done !== 23'd0 || bus.fill_bursts !== 23'd1000)
      $display("FAIL missed_sat got miss=%0d cnt=%0d size=%0d want 255 0 1000",
               bus.missed_triggers, bus.bursts_done, bus.fill_bursts);
    else pass_cnt++;
    bus.burst_valid = 1'b1;
    for (int i = 0; i < 1100 && !bus.fill_done; i++) tick();
    total_cnt++;
    if (bus.fill_done !== 1'b1 || bus.bursts_done !== 23'd1000)
      $display("FAIL laser_done got done=%b cnt=%0d want 1 1000", bus.fill_done, bus.bursts_done);
    else pass_cnt++;
    bus.trigger = 1'b1;
    ack();
    bus.trigger = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.fill_number !== 24'd3 || bus.missed_triggers !== 8'd255)
      $display("FAIL ack_trigger got busy=%b fnum=%0d miss=%0d want 0 3 255",
               bus.busy, bus.fill_number, bus.missed_triggers);
    else pass_cnt++;
  endtask

  task automatic test_size_change();
    int acc = 0;
    bus.num_ped_bursts = 23'd4;
    bus.burst_valid = 1'b0;
    bus.trigger_type = 2'b11;
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.fill_number !== 24'd4)
      $display("FAIL back_to_back got busy=%b fnum=%0d want 1 4", bus.busy, bus.fill_number);
    else pass_cnt++;
    tick();
    bus.num_ped_bursts = 23'd9;
    bus.burst_valid = 1'b1;
    for (int i = 0; i < 30 && !bus.fill_done; i++) begin
      if (bus.burst_ready) acc++;
      tick();
    end
    total_cnt++;
    if (bus.fill_done !== 1'b1 || acc != 4 || bus.bursts_done !== 23'd4 || bus.fill_bursts !== 23'd4)
      $display("FAIL ped_size got done=%b acc=%0d cnt=%0d size=%0d want 1 4 4 4",
               bus.fill_done, acc, bus.bursts_done, bus.fill_bursts);
    else pass_cnt++;
    ack();
  endtask

  task automatic test_gapped();
    int acc = 0;
    bus.num_muon_bursts = 23'd3;
    bus.burst_valid = 1'b0;
    bus.trigger_type = 2'b01;
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    for (int i = 0; i < 30 && !bus.fill_done; i++) begin
      bus.burst_valid = ~bus.burst_valid;
      if (bus.burst_valid && bus.burst_ready) acc++;
      tick();
    end
    bus.burst_valid = 1'b0;
    total_cnt++;
    if (bus.fill_done !== 1'b1 || acc != 3 || bus.bursts_done !== 23'd3 || bus.fill_number !== 24'd5)
      $display("FAIL gapped got done=%b acc=%0d cnt=%0d fnum=%0d want 1 3 3 5",
               bus.fill_done, acc, bus.bursts_done, bus.fill_number);
    else pass_cnt++;
    ack();
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    bus.num_muon_bursts = 23'd50;
    bus.burst_valid = 1'b1;
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (bus.acq_enable !== 1'b1 || bus.bursts_done !== 23'd4)
      $display("FAIL mid_running got acq=%b cnt=%0d want 1 4", bus.acq_enable, bus.bursts_done);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.acq_enable, bus.fill_done, bus.fill_type, bus.fill_bursts, bus.bursts_done,
         bus.fill_number, bus.missed_triggers} !== '0)
      $display("FAIL mid_reset got busy=%b acq=%b done=%b size=%0d cnt=%0d fnum=%0d want all 0",
               bus.busy, bus.acq_enable, bus.fill_done, bus.fill_bursts, bus.bursts_done, bus.fill_number);
    else pass_cnt++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      saw |= bus.fill_done | bus.busy;
    end
    total_cnt++;
    if (saw !== 1'b0)
      $display("FAIL mid_no_done got %b want 0", saw);
    else pass_cnt++;
  endtask

`ifdef ADC_FILL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bus.num_muon_bursts = 23'd10;
    bus.burst_valid = 1'b1;
    bus.trigger_type = 2'b01;
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    tick();
    tick();
    tick();
    bus.burst_valid = 1'b0;
    for (int i = 0; i < 300 && !bus.fill_done; i++) tick();
    total_cnt++;
    if (bus.fill_done !== 1'b1 || bus.timeout_flag !== 1'b1 || bus.bursts_done !== 23'd2)
      $display("FAIL timeout got done=%b flag=%b cnt=%0d want 1 1 2",
               bus.fill_done, bus.timeout_flag, bus.bursts_done);
    else pass_cnt++;
    ack();
  endtask
`endif

  initial begin
    bus.trigger = 1'b0;
    bus.trigger_type = 2'b00;
    bus.num_muon_bursts = '0;
    bus.num_laser_bursts = '0;
    bus.num_ped_bursts = '0;
    bus.burst_valid = 1'b0;
    bus.done_ack = 1'b0;
    test_reset();
    test_muon();
    test_none();
    test_missed();
    test_size_change();
    test_gapped();
    test_reset_mid();
`ifdef ADC_FILL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
